fetch: RTL and testbench

//  Instruction fetch stage, directly upstream of decode. Owns the PC and issues byte reads on the memory bus.

---
 rtl/fetch_if.sv | 10 +
 rtl/fetch.sv | 138 +++++++++++++
 tb/tb_fetch.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Memory read bus between the fetch stage (master) and instruction memory (slave).
interface fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (output mem_addr, output mem_rd, input mem_rdata, input mem_ack);
  modport slave  (input mem_addr, input mem_rd, output mem_rdata, output mem_ack);
endinterface

// File: rtl/fetch.sv
// SM83-style instruction fetch stage: owns the PC, fetches opcode/operand bytes, HALT sleep/wake.
// Optional macro SM83_HALT_BUG_EN reproduces the HALT bug (halt with ime=0 and wake=1 re-reads the next byte).
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     mem,
  output logic [7:0]  instr,
  output logic        instr_valid,
  output logic        is_instr16,
  input  logic        dec_is_instr16,
  input  logic        ctl_ready,
  input  logic        fetch_next,
  input  logic        imm_req,
  output logic [7:0]  imm_data,
  output logic        imm_valid,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic        halt,
  input  logic        wake,
  input  logic        ime,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    HOLD    = 3'd1,
    WAIT    = 3'd2,
    OPERAND = 3'd3,
    HALTED  = 3'd4
  } state_t;

  state_t state;
  logic   skip_inc;

  assign mem.mem_addr = pc;

`ifndef SM83_HALT_BUG_EN
  logic unused_ime;
  assign unused_ime = ime;
`endif

  // Fetch sequencer: state, PC and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 8'h00;
      imm_data    <= 8'h00;
      instr_valid <= 1'b0;
      is_instr16  <= 1'b0;
      imm_valid   <= 1'b0;
      mem.mem_rd  <= 1'b0;
      skip_inc    <= 1'b0;
    end else begin
      imm_valid <= 1'b0;
      case (state)
        FETCH: begin
          // mem_rd is only low here on the first cycle out of reset
          if (!mem.mem_rd) begin
            mem.mem_rd <= 1'b1;
          end else if (mem.mem_ack) begin
            instr       <= mem.mem_rdata;
            instr_valid <= 1'b1;
            mem.mem_rd  <= 1'b0;
            if (!skip_inc) begin
              pc <= pc + 16'd1;
            end
            skip_inc <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (ctl_ready) begin
            instr_valid <= 1'b0;
            is_instr16  <= dec_is_instr16;
            if (dec_is_instr16) begin
              mem.mem_rd <= 1'b1;
              state      <= FETCH;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (pc_load) begin
            pc <= pc_load_val;
            if (fetch_next) begin
              mem.mem_rd <= 1'b1;
              state      <= FETCH;
            end
          end else if (halt) begin
            if (wake) begin
              mem.mem_rd <= 1'b1;
              state      <= FETCH;
`ifdef SM83_HALT_BUG_EN
              skip_inc   <= !ime;
`endif
            end else begin
              state <= HALTED;
            end
          end else if (imm_req) begin
            mem.mem_rd <= 1'b1;
            state      <= OPERAND;
          end else if (fetch_next) begin
            mem.mem_rd <= 1'b1;
            state      <= FETCH;
          end
        end
        OPERAND: begin
          if (mem.mem_ack) begin
            imm_data   <= mem.mem_rdata;
            imm_valid  <= 1'b1;
            mem.mem_rd <= 1'b0;
            pc         <= pc + 16'd1;
            state      <= WAIT;
          end
        end
        HALTED: begin
          if (wake) begin
            mem.mem_rd <= 1'b1;
            state      <= FETCH;
          end
        end
        default: begin
          mem.mem_rd <= 1'b0;
          state      <= FETCH;
        end
      endcase
    end
  end

  // Control may only issue requests while the stage is idle in WAIT.
  a_req_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    (pc_load || halt || imm_req || fetch_next) |-> (state == WAIT));

endmodule

// File: tb/tb_fetch.sv
// Randomized self-checking bench for fetch with an event-level reference model.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  instr, imm_data;
  logic        instr_valid, is_instr16, imm_valid;
  logic        dec_is_instr16, ctl_ready, fetch_next, imm_req;
  logic        pc_load, halt, wake, ime;
  logic [15:0] pc_load_val, pc;

  fetch_if bus();

  fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .mem(bus),
    .instr(instr), .instr_valid(instr_valid), .is_instr16(is_instr16),
    .dec_is_instr16(dec_is_instr16), .ctl_ready(ctl_ready),
    .fetch_next(fetch_next), .imm_req(imm_req),
    .imm_data(imm_data), .imm_valid(imm_valid),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .halt(halt), .wake(wake), .ime(ime), .pc(pc)
  );

  always #5 clk = ~clk;

  // Memory: combinational data, ack after a configurable number of wait cycles
  logic [7:0] mem [0:65535];
  logic [1:0] cnt = 2'd0;
  logic [1:0] rand_delay = 2'd0;
  logic [1:0] fixed_delay = 2'd0;
  bit         rand_mode = 1'b0;

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ack   = bus.mem_rd && (cnt >= (rand_mode ? rand_delay : fixed_delay));

  always @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 2'd0;
    end else if (bus.mem_rd) begin
      if (bus.mem_ack) begin
        cnt        <= 2'd0;
        rand_delay <= 2'($urandom_range(0, 3));
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  // Reference model: what the stage is doing, in transaction terms
  logic [15:0] m_pc;
  logic [7:0]  m_instr, m_imm;
  bit m_iv, m_i16, m_immv, m_rd;
  bit m_start, m_presenting, m_idle, m_asleep, m_operand, m_skip;

  // Inputs captured before each edge
  bit s_rst_n, s_ack, s_ready, s_dec, s_fn, s_imm, s_load, s_halt, s_wake, s_ime;
  logic [15:0] s_val;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic begin_read(input bit operand);
    m_rd      = 1'b1;
    m_operand = operand;
  endtask

  task automatic model_step();
    if (!s_rst_n) begin
      m_pc = 16'h0000; m_instr = 8'h00; m_imm = 8'h00;
      m_iv = 0; m_i16 = 0; m_immv = 0; m_rd = 0;
      m_start = 1; m_presenting = 0; m_idle = 0; m_asleep = 0; m_operand = 0; m_skip = 0;
    end else begin
      m_immv = 0;
      if (m_start) begin
        m_start = 0;
        begin_read(1'b0);
      end else if (m_rd) begin
        if (s_ack) begin
          m_rd = 0;
          if (m_operand) begin
            m_imm = mem[m_pc]; m_immv = 1; m_idle = 1; m_pc = m_pc + 16'd1;
          end else begin
            m_instr = mem[m_pc]; m_iv = 1; m_presenting = 1;
            if (!m_skip) m_pc = m_pc + 16'd1;
            m_skip = 0;
          end
        end
      end else if (m_presenting) begin
        if (s_ready) begin
          m_presenting = 0; m_iv = 0; m_i16 = s_dec;
          if (s_dec) begin_read(1'b0);
          else m_idle = 1;
        end
      end else if (m_asleep) begin
        if (s_wake) begin m_asleep = 0; begin_read(1'b0); end
      end else if (m_idle) begin
        if (s_load) begin
          m_pc = s_val;
          if (s_fn) begin m_idle = 0; begin_read(1'b0); end
        end else if (s_halt) begin
          m_idle = 0;
          if (s_wake) begin
            begin_read(1'b0);
`ifdef SM83_HALT_BUG_EN
            m_skip = !s_ime;
`endif
          end else begin
            m_asleep = 1;
          end
        end else if (s_imm) begin
          m_idle = 0; begin_read(1'b1);
        end else if (s_fn) begin
          m_idle = 0; begin_read(1'b0);
        end
      end
    end
  endtask

  task automatic clr();
    rst_n = 1'b1; ctl_ready = 0; dec_is_instr16 = 0; fetch_next = 0; imm_req = 0;
    pc_load = 0; pc_load_val = 16'h0000; halt = 0; wake = 0; ime = 0;
  endtask

  task automatic tick();
    #1;
    s_rst_n = rst_n; s_ack = bus.mem_ack; s_ready = ctl_ready; s_dec = dec_is_instr16;
    s_fn = fetch_next; s_imm = imm_req; s_load = pc_load; s_val = pc_load_val;
    s_halt = halt; s_wake = wake; s_ime = ime;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_rd", 16'(bus.mem_rd), 16'(m_rd));
      chk("pc", pc, m_pc);
      if (m_rd) chk("mem_addr", bus.mem_addr, m_pc);
      chk("instr_valid", 16'(instr_valid), 16'(m_iv));
      chk("instr", 16'(instr), 16'(m_instr));
      chk("is_instr16", 16'(is_instr16), 16'(m_i16));
      chk("imm_valid", 16'(imm_valid), 16'(m_immv));
      chk("imm_data", 16'(imm_data), 16'(m_imm));
      chk("valid_overlap", 16'(instr_valid & imm_valid), 16'h0000);
    end
  end

  initial begin
    for (int a = 0; a < 65536; a++)
      mem[a] = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom_range(0, 255));
    mem[0] = 8'h3E; mem[1] = 8'h42; mem[2] = 8'hCB; mem[3] = 8'h7C; mem[4] = 8'h00;
    mem[16'h1234] = 8'h5A; mem[16'hFFFF] = 8'h77;

    clr(); rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("lit_reset_pc", pc, 16'h0000);
    chk("lit_reset_rd", 16'(bus.mem_rd), 16'h0000);
    chk("lit_reset_iv", 16'(instr_valid), 16'h0000);

    // First opcode after reset, zero-wait memory
    rst_n = 1'b1; tick();
    chk("lit_first_rd", 16'(bus.mem_rd), 16'h0001);
    tick();
    chk("lit_first_instr", 16'(instr), 16'h003E);
    chk("lit_first_iv", 16'(instr_valid), 16'h0001);
    chk("lit_first_pc", pc, 16'h0001);

    // Operand byte
    ctl_ready = 1; tick(); clr();
    imm_req = 1; tick(); clr(); tick();
    chk("lit_imm_valid", 16'(imm_valid), 16'h0001);
    chk("lit_imm_data", 16'(imm_data), 16'h0042);
    chk("lit_imm_pc", pc, 16'h0002);

    // CB-prefixed pair, suffix fetched without fetch_next
    fetch_next = 1; tick(); clr(); tick();
    ctl_ready = 1; dec_is_instr16 = 1; tick(); clr(); tick();
    chk("lit_cb_instr", 16'(instr), 16'h007C);
    chk("lit_cb_i16", 16'(is_instr16), 16'h0001);
    chk("lit_cb_pc", pc, 16'h0004);
    ctl_ready = 1; tick(); clr();
    fetch_next = 1; tick(); clr(); tick();
    chk("lit_after_cb_instr", 16'(instr), 16'h0000);
    chk("lit_after_cb_i16", 16'(is_instr16), 16'h0000);

    // Redirect with fetch_next, then a 3-cycle delayed ack
    ctl_ready = 1; tick(); clr();
    fixed_delay = 2'd3;
    pc_load = 1; pc_load_val = 16'h1234; fetch_next = 1; tick(); clr();
    for (int i = 0; i < 4; i++) begin
      chk("lit_delay_rd", 16'(bus.mem_rd), 16'h0001);
      chk("lit_delay_addr", bus.mem_addr, 16'h1234);
      chk("lit_delay_iv", 16'(instr_valid), 16'h0000);
      tick();
    end
    chk("lit_delay_instr", 16'(instr), 16'h005A);
    chk("lit_delay_valid", 16'(instr_valid), 16'h0001);
    chk("lit_delay_pc", pc, 16'h1235);
    fixed_delay = 2'd0;

    // PC wrap
    ctl_ready = 1; tick(); clr();
    pc_load = 1; pc_load_val = 16'hFFFF; fetch_next = 1; tick(); clr(); tick();
    chk("lit_wrap_instr", 16'(instr), 16'h0077);
    chk("lit_wrap_pc", pc, 16'h0000);

    // halt with wake already pending and ime=0
    ctl_ready = 1; tick(); clr();
    halt = 1; ime = 0; wake = 1; tick(); clr(); tick();
    chk("lit_hbug_instr1", 16'(instr), 16'h003E);
`ifdef SM83_HALT_BUG_EN
    chk("lit_hbug_pc1", pc, 16'h0000);
`else
    chk("lit_hbug_pc1", pc, 16'h0001);
`endif
    ctl_ready = 1; tick(); clr();
    fetch_next = 1; tick(); clr(); tick();
`ifdef SM83_HALT_BUG_EN
    chk("lit_hbug_instr2", 16'(instr), 16'h003E);
    chk("lit_hbug_pc2", pc, 16'h0001);
`else
    chk("lit_hbug_instr2", 16'(instr), 16'h0042);
    chk("lit_hbug_pc2", pc, 16'h0002);
`endif

    // Sleep for five cycles, then wake
    ctl_ready = 1; tick(); clr();
    halt = 1; tick(); clr();
    for (int i = 0; i < 5; i++) begin
      chk("lit_halted_rd", 16'(bus.mem_rd), 16'h0000);
      if (i == 4) wake = 1;
      tick();
    end
    clr();
    chk("lit_wake_rd", 16'(bus.mem_rd), 16'h0001);
    tick();
    ctl_ready = 1; tick(); clr();

    // Randomized traffic
    rand_mode = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      clr();
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
      end else if (m_presenting) begin
        ctl_ready      = 1'($urandom_range(0, 1));
        dec_is_instr16 = (m_instr == 8'hCB) && !m_i16;
      end else if (m_asleep) begin
        wake = ($urandom_range(0, 3) == 0);
      end else if (m_idle) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: fetch_next = 1;
          5, 6: imm_req = 1;
          7: begin
            pc_load     = 1;
            pc_load_val = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            fetch_next  = 1'($urandom_range(0, 1));
          end
          8: begin
            halt = 1;
            wake = 1'($urandom_range(0, 1));
            ime  = 1'($urandom_range(0, 1));
          end
          default: ;
        endcase
      end
      tick();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
